// File: rtl/druaga_spra_buffer_if.sv
// -----------------------------------------------------------------------------
// druaga_spra_buffer_if
//
// Purpose:
//   Bundles the CPU-side byte port, the vertical-blank level, the sprite-engine
//   read port and the copy status of druaga_spra_buffer into a single interface.
//
// Signals:
//   CPU_A   [8:7] bank select (3 = unmapped), [6:0] entry index
//   CPU_DO  CPU write data
//   CPU_WE  one-cycle write strobe
//   CPU_RE  one-cycle read strobe
//   CPU_DI  shadow readback data (held until the next CPU_RE)
//   VB      vertical-blank level, synchronous to VCLKx8
//   SPRA_A  active-buffer read address from the sprite engine
//   SPRA_D  {bank2, bank1, bank0} of the addressed active entry
//   BUSY    high while a shadow-to-active copy is running
//   FREEZE  only with SPRA_FREEZE_EN defined: suppresses the copy at VB rise
//
// Modports:
//   master  CPU decoder / video side (drives strobes, addresses, VB)
//   slave   the sprite-attribute buffer
// -----------------------------------------------------------------------------
interface druaga_spra_buffer_if #(
    parameter int ENTRIES = 128
);
    localparam int AW = $clog2(ENTRIES);

    logic [AW+1:0] CPU_A;
    logic [7:0]    CPU_DO;
    logic          CPU_WE;
    logic          CPU_RE;
    logic [7:0]    CPU_DI;
    logic          VB;
    logic [AW-1:0] SPRA_A;
    logic [23:0]   SPRA_D;
    logic          BUSY;
`ifdef SPRA_FREEZE_EN
    logic          FREEZE;
`endif

    modport master (
        output CPU_A,
        output CPU_DO,
        output CPU_WE,
        output CPU_RE,
        input  CPU_DI,
        output VB,
        output SPRA_A,
        input  SPRA_D,
        input  BUSY
`ifdef SPRA_FREEZE_EN
        ,
        output FREEZE
`endif
    );

    modport slave (
        input  CPU_A,
        input  CPU_DO,
        input  CPU_WE,
        input  CPU_RE,
        output CPU_DI,
        input  VB,
        input  SPRA_A,
        output SPRA_D,
        output BUSY
`ifdef SPRA_FREEZE_EN
        ,
        input  FREEZE
`endif
    );

endinterface

// File: rtl/druaga_spra_buffer.sv
// -----------------------------------------------------------------------------
// druaga_spra_buffer
//
// Purpose:
//   Double-buffered sprite-attribute RAM. The CPU writes bytes into a shadow
//   buffer (3 banks x ENTRIES x 8 bits); on every vertical-blank rising edge a
//   copy engine moves all entries into the active buffer that the sprite engine
//   reads, so a frame is never rendered from a half-updated table.
//
// Ports:
//   VCLKx8   single clock, all logic on its rising edge
//   RESET_N  asynchronous active-low reset
//   bus      druaga_spra_buffer_if.slave (CPU port, VB, SPRA port, BUSY)
//
// Parameters:
//   ENTRIES  entries per bank, power of two
//   RD_LAT   shadow read latency seen by the copy engine; only 1 is supported
//
// Optional feature (macro SPRA_FREEZE_EN):
//   Adds bus.FREEZE. FREEZE high at the VB rising edge suppresses that frame's
//   copy. Without the macro every VB rising edge seen in IDLE starts a copy.
//
// States:
//   S_IDLE | waiting for a VB rising edge, BUSY low
//   S_COPY | one shadow entry read per cycle, previous entry written to active
//   S_LAST | final entry written to active, BUSY drops on exit
// -----------------------------------------------------------------------------
module druaga_spra_buffer #(
    parameter int ENTRIES = 128,
    parameter int RD_LAT  = 1
) (
    input  logic                 VCLKx8,
    input  logic                 RESET_N,
    druaga_spra_buffer_if.slave  bus
);
    localparam int            AW       = $clog2(ENTRIES);
    localparam logic [AW-1:0] LAST_IDX = AW'(ENTRIES - 1);
    localparam logic [AW-1:0] LAT_IDX  = AW'(RD_LAT);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COPY = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] copy_idx;
    logic          vb_d;
    logic          busy_q;
    logic [7:0]    cpu_di_q;
    logic [23:0]   spra_d_q;
    logic [23:0]   copy_data;

    logic [23:0]   shadow_mem [ENTRIES];
    logic [23:0]   active_mem [ENTRIES];

    logic [1:0]    cpu_bank;
    logic [AW-1:0] cpu_idx;
    logic          cpu_mapped;
    logic [7:0]    cpu_rd_byte;
    logic          vb_start;
    logic          copy_go;
    logic          act_we;
    logic [AW-1:0] act_wa;

    assign cpu_bank   = bus.CPU_A[AW+1:AW];
    assign cpu_idx    = bus.CPU_A[AW-1:0];
    assign cpu_mapped = (cpu_bank != 2'd3);

    assign vb_start = bus.VB & ~vb_d;

`ifdef SPRA_FREEZE_EN
    assign copy_go = vb_start & ~bus.FREEZE;
`else
    assign copy_go = vb_start;
`endif

    // The active write trails the shadow read by RD_LAT cycles; S_LAST only
    // exists to drain the final entry out of copy_data.
    assign act_we = ((state == S_COPY) && (copy_idx >= LAT_IDX)) || (state == S_LAST);
    assign act_wa = (state == S_LAST) ? LAST_IDX : (copy_idx - LAT_IDX);

    always_comb begin
        cpu_rd_byte = 8'hFF;
        case (cpu_bank)
            2'd0:    cpu_rd_byte = shadow_mem[cpu_idx][7:0];
            2'd1:    cpu_rd_byte = shadow_mem[cpu_idx][15:8];
            2'd2:    cpu_rd_byte = shadow_mem[cpu_idx][23:16];
            default: cpu_rd_byte = 8'hFF;
        endcase
    end

    // Storage: not reset. The copy read and the CPU write share an edge, so a
    // collision on the same entry hands the copy the old data.
    always_ff @(posedge VCLKx8) begin
        if (bus.CPU_WE && cpu_mapped) begin
            case (cpu_bank)
                2'd0:    shadow_mem[cpu_idx][7:0]   <= bus.CPU_DO;
                2'd1:    shadow_mem[cpu_idx][15:8]  <= bus.CPU_DO;
                default: shadow_mem[cpu_idx][23:16] <= bus.CPU_DO;
            endcase
        end
        if (state == S_COPY) begin
            copy_data <= shadow_mem[copy_idx];
        end
        if (act_we) begin
            active_mem[act_wa] <= copy_data;
        end
    end

    // Readback ports. The CPU read uses its own shadow port, so it is never
    // held off by a running copy.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_di_q <= 8'h00;
            spra_d_q <= 24'h000000;
        end else begin
            if (bus.CPU_RE) begin
                cpu_di_q <= cpu_rd_byte;
            end
            spra_d_q <= active_mem[bus.SPRA_A];
        end
    end

    // Copy sequencer. A VB edge while not in S_IDLE is simply not looked at.
    always_ff @(posedge VCLKx8 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            copy_idx <= '0;
            busy_q   <= 1'b0;
            vb_d     <= 1'b0;
        end else begin
            vb_d <= bus.VB;
            case (state)
                S_IDLE: begin
                    if (copy_go) begin
                        state    <= S_COPY;
                        copy_idx <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_COPY: begin
                    if (copy_idx == LAST_IDX) begin
                        state <= S_LAST;
                    end else begin
                        copy_idx <= copy_idx + ONE_IDX;
                    end
                end
                S_LAST: begin
                    state    <= S_IDLE;
                    copy_idx <= '0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    copy_idx <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CPU_DI = cpu_di_q;
    assign bus.SPRA_D = spra_d_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_druaga_spra_buffer.sv
// -----------------------------------------------------------------------------
// tb_druaga_spra_buffer
//
// Purpose:
//   Self-checking bench for druaga_spra_buffer. A behavioural model of the
//   shadow and active tables supplies expected read data, which is queued when
//   a read is issued and popped when the registered output appears.
// -----------------------------------------------------------------------------
module tb_druaga_spra_buffer;
    localparam int ENTRIES = 128;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    druaga_spra_buffer_if #(.ENTRIES(ENTRIES)) bus ();

    druaga_spra_buffer #(
        .ENTRIES (ENTRIES),
        .RD_LAT  (1)
    ) dut (
        .VCLKx8  (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] m_shadow [ENTRIES];
    logic [23:0] m_active [ENTRIES];
    logic [23:0] snap     [ENTRIES];

    logic [23:0] sb_exp [$];
    string       sb_tag [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop(input logic [23:0] got);
        if (sb_exp.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            chk(sb_tag.pop_front(), {8'h00, got}, {8'h00, sb_exp.pop_front()});
        end
    endtask

    function automatic logic [7:0] m_byte(input logic [1:0] bank, input logic [6:0] idx);
        if (bank == 2'd3) return 8'hFF;
        return m_shadow[idx][int'(bank)*8 +: 8];
    endfunction

    task automatic cpu_write(input logic [1:0] bank, input logic [6:0] idx, input logic [7:0] data);
        bus.CPU_A  = {bank, idx};
        bus.CPU_DO = data;
        bus.CPU_WE = 1'b1;
        tick();
        bus.CPU_WE = 1'b0;
        if (bank != 2'd3) m_shadow[idx][int'(bank)*8 +: 8] = data;
    endtask

    task automatic cpu_read(input string tag, input logic [1:0] bank, input logic [6:0] idx);
        sb_exp.push_back({16'h0000, m_byte(bank, idx)});
        sb_tag.push_back(tag);
        bus.CPU_A  = {bank, idx};
        bus.CPU_RE = 1'b1;
        tick();
        bus.CPU_RE = 1'b0;
        sb_pop({16'h0000, bus.CPU_DI});
    endtask

    task automatic spra_read(input string tag, input logic [6:0] addr);
        sb_exp.push_back(m_active[addr]);
        sb_tag.push_back(tag);
        bus.SPRA_A = addr;
        tick();
        sb_pop(bus.SPRA_D);
    endtask

    // One full frame copy. Optionally a second VB rise at copy cycle vb2_at and
    // a CPU write at copy cycle wr_at (cycle 0 = the VB start edge).
    task automatic run_copy(input int vb2_at, input int wr_at, input logic [1:0] wr_bank,
                            input logic [6:0] wr_idx, input logic [7:0] wr_data);
        int rel;
        foreach (snap[i]) snap[i] = m_shadow[i];
        bus.VB = 1'b1;
        tick();
        bus.VB = 1'b0;
        rel = 0;
        chk("busy_rise", {31'd0, bus.BUSY}, 32'd1);
        while (bus.BUSY === 1'b1 && rel < 300) begin
            if (rel + 1 == vb2_at) bus.VB = 1'b1;
            if (rel + 1 == wr_at) begin
                bus.CPU_A  = {wr_bank, wr_idx};
                bus.CPU_DO = wr_data;
                bus.CPU_WE = 1'b1;
                m_shadow[wr_idx][int'(wr_bank)*8 +: 8] = wr_data;
                // entry idx is fetched at copy cycle idx+1: an earlier write
                // makes it into this frame, a write at that cycle or later does not
                if (wr_at <= int'(wr_idx)) snap[wr_idx][int'(wr_bank)*8 +: 8] = wr_data;
            end
            tick();
            rel++;
            bus.VB     = 1'b0;
            bus.CPU_WE = 1'b0;
        end
        chk("copy_len", rel, 32'd129);
        foreach (m_active[i]) m_active[i] = snap[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.CPU_A  = '0;
        bus.CPU_DO = '0;
        bus.CPU_WE = 1'b0;
        bus.CPU_RE = 1'b0;
        bus.VB     = 1'b0;
        bus.SPRA_A = '0;
`ifdef SPRA_FREEZE_EN
        bus.FREEZE = 1'b0;
`endif
        #12;
        chk("rst_spra_d", {8'h00, bus.SPRA_D}, 32'd0);
        chk("rst_cpu_di", {24'h0, bus.CPU_DI}, 32'd0);
        chk("rst_busy",   {31'd0, bus.BUSY},   32'd0);
        #5 rst_n = 1'b1;
        tick();

        // Give every entry a known value so the model covers the whole table.
        for (int i = 0; i < ENTRIES; i++)
            for (int b = 0; b < 3; b++)
                cpu_write(2'(b), 7'(i), 8'((i * 5 + b * 64 + 3) & 8'hFF));
        run_copy(-1, -1, 2'd0, 7'd0, 8'h00);
        spra_read("init_0",   7'd0);
        spra_read("init_64",  7'd64);
        spra_read("init_127", 7'd127);

        // Basic frame copy.
        cpu_write(2'd0, 7'd5, 8'h11);
        cpu_write(2'd1, 7'd5, 8'h22);
        cpu_write(2'd2, 7'd5, 8'h33);
        run_copy(-1, -1, 2'd0, 7'd0, 8'h00);
        spra_read("frame_idx5", 7'd5);
        chk("frame_idx5_const", {8'h00, bus.SPRA_D}, 32'h00332211);

        // Shadow write without VB stays invisible to video.
        cpu_write(2'd0, 7'd5, 8'hAA);
        spra_read("no_vb_idx5", 7'd5);
        cpu_read("cpu_rd_b0i5", 2'd0, 7'd5);
        tick(); tick(); tick();
        chk("cpu_di_hold", {24'h0, bus.CPU_DI}, 32'h000000AA);

        // Simultaneous write and read of the same address returns old data.
        sb_exp.push_back({16'h0000, m_byte(2'd1, 7'd5)});
        sb_tag.push_back("we_re_old");
        bus.CPU_A  = {2'd1, 7'd5};
        bus.CPU_DO = 8'h99;
        bus.CPU_WE = 1'b1;
        bus.CPU_RE = 1'b1;
        tick();
        bus.CPU_WE = 1'b0;
        bus.CPU_RE = 1'b0;
        m_shadow[5][15:8] = 8'h99;
        sb_pop({16'h0000, bus.CPU_DI});
        cpu_read("we_re_new", 2'd1, 7'd5);

        // Writes during a copy: ahead of the copy, behind it, and colliding.
        run_copy(-1, 10, 2'd1, 7'd100, 8'h5C);
        spra_read("wr_ahead_100", 7'd100);
        chk("wr_ahead_byte", {24'h0, bus.SPRA_D[15:8]}, 32'h5C);
        run_copy(-1, 10, 2'd1, 7'd2, 8'hC3);
        spra_read("wr_behind_2", 7'd2);
        run_copy(-1, 10, 2'd2, 7'd9, 8'hE7);
        spra_read("wr_collide_9", 7'd9);
        spra_read("wr_behind_2_next", 7'd2);
        run_copy(-1, -1, 2'd0, 7'd0, 8'h00);
        spra_read("wr_collide_9_next", 7'd9);

        // Second VB rise mid-copy is ignored and not queued.
        run_copy(50, -1, 2'd0, 7'd0, 8'h00);
        for (int k = 0; k < 5; k++) tick();
        chk("no_requeue", {31'd0, bus.BUSY}, 32'd0);

        // Bank 3 is unmapped.
        cpu_write(2'd3, 7'd0, 8'h77);
        cpu_read("b3_b0", 2'd0, 7'd0);
        cpu_read("b3_b1", 2'd1, 7'd0);
        cpu_read("b3_b2", 2'd2, 7'd0);
        cpu_read("b3_ff", 2'd3, 7'd0);
        run_copy(-1, -1, 2'd0, 7'd0, 8'h00);
        spra_read("b3_active0", 7'd0);

        // Reset in the middle of a copy.
        for (int i = 0; i < ENTRIES; i++) cpu_write(2'd0, 7'(i), ~m_shadow[i][7:0]);
        foreach (snap[i]) snap[i] = m_shadow[i];
        bus.VB = 1'b1;
        tick();
        bus.VB = 1'b0;
        for (int k = 0; k < 64; k++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {31'd0, bus.BUSY},   32'd0);
        chk("midrst_spra_d", {8'h00, bus.SPRA_D}, 32'd0);
        for (int i = 0; i <= 62; i++) m_active[i] = snap[i];
        #2 rst_n = 1'b1;
        tick();
        chk("midrst_idle", {31'd0, bus.BUSY}, 32'd0);
        for (int i = 0; i <= 62; i++) spra_read("midrst_new", 7'(i));
        for (int i = 64; i < ENTRIES; i++) spra_read("midrst_old", 7'(i));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
